fpdiv_share_arbiter: RTL and testbench

//  Shares one fpdiv_clk_parameter reciprocal engine plus one qmult among NREQ requesters
//  in the encoder, such as the LPC, pitch and energy stages.

---
 rtl/fpdiv_pkg.sv | 19 +
 rtl/fpdiv_share_arbiter_rr_pick.sv | 31 +++
 rtl/fpdiv_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_fpdiv_share_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared constants and FSM state encoding for the shared reciprocal/multiply arbiter.
package fpdiv_pkg;
  localparam int Q_DEF = 32;
  localparam int N_DEF = 48;

  // Sign-magnitude constants for the default word format.
  localparam logic [N_DEF-1:0] ONE     = N_DEF'(1) << Q_DEF;
  localparam logic [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] MAX_NEG = {N_DEF{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    MUL   = 3'd3,
    ZERO  = 3'd4,
    RESP  = 3'd5
  } state_t;
endpackage

// File: rtl/fpdiv_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, in circular order.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   gnt_idx_o,
  output logic            any_o
);

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest pending requester wins.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[wrap(ptr_i, i)]) begin
        gnt_idx_o = wrap(ptr_i, i);
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpdiv_share_arbiter.sv
// Shares one external reciprocal engine and an internal qmult among NREQ requesters,
// computing num * (1/den) in sign-magnitude Q fixed point with zero/timeout guards.
module fpdiv_share_arbiter
  import fpdiv_pkg::*;
#(
  parameter int Q       = Q_DEF,
  parameter int N       = N_DEF,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_num,
  input  logic [NREQ*N-1:0] req_den,
  output logic [NREQ-1:0]   ack,
  output logic [N-1:0]      res,
  output logic              err,
  output logic              busy,
  output logic              div_start,
  output logic [N-1:0]      div_in,
  input  logic [N-1:0]      div_ans,
  input  logic              div_done
);

  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {N{1'b1}};

  // Sign-magnitude multiply; magnitude saturates when the product overflows N-1 bits.
  function automatic logic [N-1:0] qmult(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-3:0] prod;
    logic [N-2:0]   mag;
    prod = a[N-2:0] * b[N-2:0];
    mag  = prod[N-2+Q:Q];
    if (|prod[2*N-3:N-1+Q]) mag = '1;
    return {a[N-1] ^ b[N-1], mag};
  endfunction

  state_t            state_q;
  logic [PW-1:0]     ptr_q, g_q;
  logic [WDW-1:0]    wdog_q;
  logic              err_r_q;
  logic [NREQ-1:0]   ack_q;
  logic [N-1:0]      res_q, div_in_q;
  logic              err_q, busy_q, div_start_q;
  logic [N-1:0]      num_q, den_q, recip_q, res_r_q;

  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [N-1:0]      pick_num, pick_den;
  logic              grant, wdog_expired;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .gnt_idx_o(pick_idx),
    .any_o    (pick_any)
  );

  assign pick_num     = req_num[int'(pick_idx)*N +: N];
  assign pick_den     = req_den[int'(pick_idx)*N +: N];
  assign grant        = (state_q == IDLE) && pick_any;
  assign wdog_expired = (state_q == WAIT) && !div_done && (wdog_q == WDW'(TIMEOUT));

  // The watchdog holds during the start cycle so it only counts cycles the divider is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      wdog_q      <= '0;
      err_r_q     <= 1'b0;
      ack_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
      div_in_q    <= '0;
    end else begin
      ack_q       <= '0;
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= pick_any;
          if (pick_any) begin
            g_q     <= pick_idx;
            state_q <= (pick_den[N-2:0] == '0) ? ZERO : ISSUE;
          end
        end
        ISSUE: begin
          div_in_q    <= den_q;
          div_start_q <= 1'b1;
          wdog_q      <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            state_q <= MUL;
          end else if (wdog_expired) begin
            err_r_q <= 1'b1;
            state_q <= RESP;
          end else if (!div_start_q) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        MUL: begin
          err_r_q <= 1'b0;
          state_q <= RESP;
        end
        ZERO: begin
          err_r_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          ack_q   <= NREQ'(1) << g_q;
          res_q   <= res_r_q;
          err_q   <= err_r_q;
          ptr_q   <= (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand and result datapath; contents are only consumed after being written.
  always_ff @(posedge clk) begin
    if (grant) begin
      num_q <= pick_num;
      den_q <= pick_den;
    end
    if (state_q == WAIT && div_done) recip_q <= div_ans;
    if (wdog_expired)                res_r_q <= '0;
    if (state_q == MUL)              res_r_q <= qmult(num_q, recip_q);
    if (state_q == ZERO)             res_r_q <= num_q[N-1] ? SAT_NEG : SAT_POS;
  end

  assign ack       = ack_q;
  assign res       = res_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign div_start = div_start_q;
  assign div_in    = div_in_q;

endmodule

// File: tb/tb_fpdiv_share_arbiter.sv
// Directed bench for fpdiv_share_arbiter with a behavioural reciprocal stub.
module tb_fpdiv_share_arbiter;
  import fpdiv_pkg::*;

  localparam int Q = 32, N = 48, NREQ = 4, TIMEOUT = 1023, DIV_LAT = 4;
  localparam logic [N-1:0] TOL       = 48'h000000001000;
  localparam logic [N-1:0] HALF      = 48'h000080000000;
  localparam logic [N-1:0] QUART     = 48'h000040000000;
  localparam logic [N-1:0] ONE_HALF  = 48'h000180000000;
  localparam logic [N-1:0] TWO       = 48'h000200000000;
  localparam logic [N-1:0] THREE     = 48'h000300000000;
  localparam logic [N-1:0] FOUR      = 48'h000400000000;
  localparam logic [N-1:0] NEG_FOUR  = 48'h800400000000;
  localparam logic [N-1:0] NEG_QUART = 48'h800040000000;
  localparam logic [N-1:0] NEG_ZERO  = 48'h800000000000;
  localparam logic [N-1:0] NEG_ONE   = 48'h800100000000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_num, req_den;
  logic [NREQ-1:0]   ack;
  logic [N-1:0]      res;
  logic              err, busy, div_start;
  logic [N-1:0]      div_in;
  logic [N-1:0]      div_ans;
  logic              div_done;

  int checks = 0, failures = 0;
  int cyc = 0, starts = 0, cnt = 0;
  bit hang = 0;
  logic [N-1:0] diff;

  fpdiv_share_arbiter #(.Q(Q), .N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_num(req_num), .req_den(req_den),
    .ack(ack), .res(res), .err(err), .busy(busy), .div_start(div_start),
    .div_in(div_in), .div_ans(div_ans), .div_done(div_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [N-1:0] recip(input logic [N-1:0] d);
    logic [95:0] qt;
    qt = (96'h1 << 64) / {49'b0, d[N-2:0]};
    return {d[N-1], qt[N-2:0]};
  endfunction

  // Reciprocal stub: start is taken at the edge after it is seen, done pulses DIV_LAT cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      cnt = 0;
      div_done = 1'b0;
      div_ans = '0;
    end else begin
      div_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done = 1'b1;
          div_ans = recip(div_in);
        end
      end
      if (div_start) begin
        starts++;
        if (!hang) cnt = DIV_LAT + 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic set_op(input int k, input logic [N-1:0] n, input logic [N-1:0] d);
    req_num[k*N +: N] = n;
    req_den[k*N +: N] = d;
  endtask

  task automatic wait_busy(output bit ok, output int gcyc);
    ok = 0;
    gcyc = cyc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1;
        gcyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ack !== '0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
    checks++; if (res !== '0) begin failures++; $display("FAIL reset_res got=%h want=0", res); end
    checks++; if ({err, busy, div_start} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {err, busy, div_start}); end
    checks++; if (div_in !== '0) begin failures++; $display("FAIL reset_div_in got=%h want=0", div_in); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_divide();
    bit ok; int g; int s0;
    s0 = starts;
    set_op(0, THREE, TWO);
    req = 4'b0001;
    wait_busy(ok, g);
    checks++; if (!ok) begin failures++; $display("FAIL t1_grant got=none want=busy"); end
    wait_ack(40, ok);
    req = 4'b0000;
    checks++; if (!ok) begin failures++; $display("FAIL t1_ack_wait got=none want=ack"); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL t1_ack got=%b want=0001", ack); end
    diff = (res > ONE_HALF) ? res - ONE_HALF : ONE_HALF - res;
    checks++; if (diff > TOL) begin failures++; $display("FAIL t1_res got=%h want=%h", res, ONE_HALF); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t1_err got=%b want=0", err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_at_ack got=%b want=1", busy); end
    checks++; if (cyc - g != 5 + DIV_LAT) begin failures++; $display("FAIL t1_latency got=%0d want=%0d", cyc - g, 5 + DIV_LAT); end
    checks++; if (starts - s0 != 1) begin failures++; $display("FAIL t1_start_count got=%0d want=1", starts - s0); end
    @(negedge clk);
    checks++; if ({ack, busy} !== 5'b0) begin failures++; $display("FAIL t1_after_ack got=%b want=00000", {ack, busy}); end
  endtask

  task automatic test_div_zero();
    bit ok; int g; int s0;
    s0 = starts;
    set_op(1, ONE, NEG_ZERO);
    req = 4'b0010;
    wait_busy(ok, g);
    checks++; if (!ok) begin failures++; $display("FAIL t3_grant got=none want=busy"); end
    wait_ack(20, ok);
    req = 4'b0000;
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL t3_ack got=%b want=0010", ack); end
    checks++; if (cyc - g != 2) begin failures++; $display("FAIL t3_latency got=%0d want=2", cyc - g); end
    checks++; if (res !== MAX_POS) begin failures++; $display("FAIL t3_res got=%h want=%h", res, MAX_POS); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL t3_err got=%b want=1", err); end
    checks++; if (starts != s0) begin failures++; $display("FAIL t3_no_start got=%0d want=0", starts - s0); end
    @(negedge clk);
  endtask

  task automatic test_negative();
    bit ok; int g;
    set_op(2, ONE, NEG_FOUR);
    req = 4'b0100;
    wait_busy(ok, g);
    wait_ack(40, ok);
    req = 4'b0000;
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL t2_ack got=%b want=0100", ack); end
    diff = (res > NEG_QUART) ? res - NEG_QUART : NEG_QUART - res;
    checks++; if (diff > TOL) begin failures++; $display("FAIL t2_res got=%h want=%h", res, NEG_QUART); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t2_err got=%b want=0", err); end
    @(negedge clk);
  endtask

  task automatic test_zero_negnum();
    bit ok;
    set_op(3, NEG_ONE, '0);
    req = 4'b1000;
    wait_ack(20, ok);
    req = 4'b0000;
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL zneg_ack got=%b want=1000", ack); end
    checks++; if (res !== MAX_NEG) begin failures++; $display("FAIL zneg_res got=%h want=%h", res, MAX_NEG); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL zneg_err got=%b want=1", err); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_idx [6];
    logic [N-1:0] exp_res [6];
    bit exp_err [6];
    logic [NREQ-1:0] want;
    exp_idx = '{0, 1, 2, 3, 0, 3};
    exp_res = '{ONE, HALF, QUART, MAX_POS, ONE, MAX_POS};
    exp_err = '{0, 0, 0, 1, 0, 1};
    set_op(0, ONE, ONE);
    set_op(1, ONE, TWO);
    set_op(2, ONE, FOUR);
    set_op(3, ONE, '0);
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_ack(60, ok);
      want = NREQ'(1) << exp_idx[i];
      checks++; if (ack !== want) begin failures++; $display("FAIL t4_order[%0d] got=%b want=%b", i, ack, want); end
      diff = (res > exp_res[i]) ? res - exp_res[i] : exp_res[i] - res;
      checks++; if (diff > TOL) begin failures++; $display("FAIL t4_res[%0d] got=%h want=%h", i, res, exp_res[i]); end
      checks++; if (err !== exp_err[i]) begin failures++; $display("FAIL t4_err[%0d] got=%b want=%b", i, err, exp_err[i]); end
      if (i == 3) req = 4'b1001;
      if (i == 5) req = 4'b0000;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; int g;
    hang = 1;
    set_op(0, ONE, TWO);
    req = 4'b0001;
    wait_busy(ok, g);
    wait_ack(TIMEOUT + 50, ok);
    req = 4'b0000;
    checks++; if (!ok) begin failures++; $display("FAIL t5_ack_wait got=none want=ack"); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL t5_ack got=%b want=0001", ack); end
    checks++; if (cyc - g != TIMEOUT + 4) begin failures++; $display("FAIL t5_latency got=%0d want=%0d", cyc - g, TIMEOUT + 4); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL t5_err got=%b want=1", err); end
    checks++; if (res !== '0) begin failures++; $display("FAIL t5_res got=%h want=0", res); end
    hang = 0;
    @(negedge clk);
    set_op(1, THREE, TWO);
    req = 4'b0010;
    wait_ack(60, ok);
    req = 4'b0000;
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL t5_next_ack got=%b want=0010", ack); end
    diff = (res > ONE_HALF) ? res - ONE_HALF : ONE_HALF - res;
    checks++; if (diff > TOL) begin failures++; $display("FAIL t5_next_res got=%h want=%h", res, ONE_HALF); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t5_next_err got=%b want=0", err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    bit ok; int g; int acks;
    hang = 1;
    set_op(0, ONE, TWO);
    req = 4'b0001;
    wait_busy(ok, g);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({ack, err, busy, div_start} !== 7'b0) begin failures++; $display("FAIL t6_ctrl_zero got=%b want=0", {ack, err, busy, div_start}); end
    checks++; if (res !== '0) begin failures++; $display("FAIL t6_res_zero got=%h want=0", res); end
    checks++; if (div_in !== '0) begin failures++; $display("FAIL t6_div_in_zero got=%h want=0", div_in); end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL t6_no_ack got=%0d want=0", acks); end
    hang = 0;
    rst = 1'b1;
    wait_ack(60, ok);
    req = 4'b0000;
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL t6_regrant_ack got=%b want=0001", ack); end
    diff = (res > HALF) ? res - HALF : HALF - res;
    checks++; if (diff > TOL) begin failures++; $display("FAIL t6_regrant_res got=%h want=%h", res, HALF); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t6_regrant_err got=%b want=0", err); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req_num = '0;
    req_den = '0;
    test_reset();
    test_single_divide();
    test_div_zero();
    test_negative();
    test_zero_negnum();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
